dmem_wait: RTL and testbench

- Parametrised data memory for the processor's data port; successor to the fixed-timing dmem.
- Adds a configurable wait-state count, a registered request/valid handshake, a busy indication, and out-of-range/misalignment error reporting.
- Sits between the processor's op_data_* outputs and its ip_data_* inputs; drops into the existing tb.
- Contents live in word array `mem`, so they can be loaded with $readmemh and dumped by index.

---
 rtl/dmem_wait.sv | 138 +++++++++++++
 tb/tb_dmem_wait.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait.sv
// Data memory with configurable wait states and a registered valid handshake.
// Out-of-range or misaligned accesses complete with op_data_err set.
module dmem_wait #(
  parameter int SIZE_IN_BYTES = 8,
  parameter int LATENCY       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_dmem,
  output logic        op_data_busy,
  output logic        op_data_err
);

  localparam int DEPTH = SIZE_IN_BYTES / 4;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic          do_access;
  logic          acc_err;
  logic          mem_we;
  logic [AW-1:0] idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ip_data_rd || ip_data_wr) begin
          addr_d  = ip_data_addr;
          mask_d  = ip_data_mask;
          wdata_d = ip_data_from_proc;
          rd_d    = ip_data_rd;
          wr_d    = ip_data_wr;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access always uses the *_d view so a zero-latency accept
  // sees the live inputs while a delayed one sees the captured copy.
  always_comb begin
    acc_err = (addr_d[1:0] != 2'b00) ||
              (addr_d >= 32'(SIZE_IN_BYTES));
    idx     = addr_d[AW+1:2];
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    if (do_access) begin
      err_d = acc_err;
      if (rd_d) rdata_d = acc_err ? 32'd0 : mem[idx];
      mem_we = wr_d && !acc_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_d[i]) mem[idx][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  assign op_data_valid     = (state_q == RESP);
  assign op_data_busy      = (state_q != IDLE);
  assign op_data_err       = (state_q == RESP) && err_q;
  assign op_data_from_dmem = rdata_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: three instances with LATENCY 2, 0 and 3.
// Table of accesses on the LATENCY=2 instance plus multi-cycle sequences.
module tb_dmem_wait;

  logic        clk;
  logic        reset;
  logic [31:0] addr  [3];
  logic        wr    [3];
  logic [3:0]  mask  [3];
  logic [31:0] wdata [3];
  logic        rd    [3];
  logic        valid [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
  logic        err   [3];

  int checks = 0;
  int failures = 0;

  dmem_wait #(.SIZE_IN_BYTES(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .ip_data_addr(addr[0]), .ip_data_wr(wr[0]),
    .ip_data_mask(mask[0]), .ip_data_from_proc(wdata[0]),
    .ip_data_rd(rd[0]), .op_data_valid(valid[0]),
    .op_data_from_dmem(rdata[0]), .op_data_busy(busy[0]),
    .op_data_err(err[0])
  );

  dmem_wait #(.SIZE_IN_BYTES(8), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset),
    .ip_data_addr(addr[1]), .ip_data_wr(wr[1]),
    .ip_data_mask(mask[1]), .ip_data_from_proc(wdata[1]),
    .ip_data_rd(rd[1]), .op_data_valid(valid[1]),
    .op_data_from_dmem(rdata[1]), .op_data_busy(busy[1]),
    .op_data_err(err[1])
  );

  dmem_wait #(.SIZE_IN_BYTES(8), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .ip_data_addr(addr[2]), .ip_data_wr(wr[2]),
    .ip_data_mask(mask[2]), .ip_data_from_proc(wdata[2]),
    .ip_data_rd(rd[2]), .op_data_valid(valid[2]),
    .op_data_from_dmem(rdata[2]), .op_data_busy(busy[2]),
    .op_data_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns after a negedge with the DUT idle.
  task automatic do_acc(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] wd,
                        output logic [31:0] rdat, output logic e,
                        output int lat);
    rd[d] = r; wr[d] = w; addr[d] = a; mask[d] = m; wdata[d] = wd;
    @(posedge clk);
    lat = -1;
    rdat = 32'hx;
    e = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid[d]) begin
        lat = n;
        rdat = rdata[d];
        e = err[d];
        break;
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] got_d;
  logic        got_e;
  int          got_l;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rd[d] = 0; wr[d] = 0; addr[d] = 0; mask[d] = 0; wdata[d] = 0;
    end
    tbl[0]  = '{0, 1, 32'd0,  4'hF, 32'h11223344, 0, 32'h00000000};
    tbl[1]  = '{0, 1, 32'd4,  4'hF, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[2]  = '{1, 0, 32'd4,  4'h0, 32'h00000000, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 1, 32'd0,  4'h5, 32'hAABBCCDD, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 0, 32'd0,  4'h0, 32'h00000000, 0, 32'h11BB33DD};
    tbl[5]  = '{0, 1, 32'd4,  4'hF, 32'h00000005, 0, 32'h11BB33DD};
    tbl[6]  = '{1, 1, 32'd4,  4'hF, 32'hFFFFFFFF, 0, 32'h00000005};
    tbl[7]  = '{1, 0, 32'd4,  4'h0, 32'h00000000, 0, 32'hFFFFFFFF};
    tbl[8]  = '{1, 0, 32'd8,  4'h0, 32'h00000000, 1, 32'h00000000};
    tbl[9]  = '{0, 1, 32'd2,  4'hF, 32'h12345678, 1, 32'h00000000};
    tbl[10] = '{1, 0, 32'd0,  4'h0, 32'h00000000, 0, 32'h11BB33DD};
    tbl[11] = '{0, 1, 32'd0,  4'h0, 32'hFFFFFFFF, 0, 32'h11BB33DD};
    tbl[12] = '{1, 0, 32'd0,  4'h0, 32'h00000000, 0, 32'h11BB33DD};
    tbl[13] = '{1, 0, 32'd6,  4'h0, 32'h00000000, 1, 32'h00000000};
    tbl[14] = '{1, 1, 32'd12, 4'hF, 32'h0F0F0F0F, 1, 32'h00000000};
    tbl[15] = '{1, 0, 32'd4,  4'h0, 32'h00000000, 0, 32'hFFFFFFFF};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), 32'(valid[d]), 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_data%0d", d), rdata[d], 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      do_acc(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].mask,
             tbl[i].wdata, got_d, got_e, got_l);
      chk($sformatf("v%0d_lat", i), 32'(got_l), 32'd3);
      chk($sformatf("v%0d_err", i), 32'(got_e), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_data", i), got_d, tbl[i].exp_data);
    end

    // Held read on LATENCY=2: single valid pulse, busy for 3 cycles.
    do_acc(0, 0, 1, 32'd4, 4'hF, 32'hDEADBEEF, got_d, got_e, got_l);
    rd[0] = 1; addr[0] = 32'd4;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("hold_valid%0d", n), 32'(valid[0]), 32'(n == 3));
      chk($sformatf("hold_busy%0d", n), 32'(busy[0]), 32'(n <= 3));
      chk($sformatf("hold_err%0d", n), 32'(err[0]), 32'd0);
      if (n == 3) chk("hold_data", rdata[0], 32'hDEADBEEF);
      if (n == 4) rd[0] = 0;
    end
    @(negedge clk);

    // LATENCY=0 back-to-back held reads.
    do_acc(1, 0, 1, 32'd0, 4'hF, 32'hA5A5A5A5, got_d, got_e, got_l);
    do_acc(1, 0, 1, 32'd4, 4'hF, 32'h5A5A5A5A, got_d, got_e, got_l);
    rd[1] = 1; addr[1] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk("l0_v1", 32'(valid[1]), 32'd1);
    chk("l0_d1", rdata[1], 32'hA5A5A5A5);
    addr[1] = 32'd4;
    @(negedge clk);
    chk("l0_v2", 32'(valid[1]), 32'd0);
    @(negedge clk);
    chk("l0_v3", 32'(valid[1]), 32'd1);
    chk("l0_d3", rdata[1], 32'h5A5A5A5A);
    rd[1] = 0;
    @(negedge clk);
    chk("l0_v4", 32'(valid[1]), 32'd0);

    // LATENCY=3: inputs changed during WAIT are ignored.
    do_acc(2, 0, 1, 32'd0, 4'hF, 32'hCAFEF00D, got_d, got_e, got_l);
    do_acc(2, 0, 1, 32'd4, 4'hF, 32'h0BADF00D, got_d, got_e, got_l);
    rd[2] = 1; addr[2] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    addr[2] = 32'd4; wr[2] = 1; mask[2] = 4'hF; wdata[2] = 32'h0;
    got_l = -1;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (valid[2]) begin got_l = n; got_d = rdata[2]; break; end
    end
    chk("l3_lat", 32'(got_l), 32'd4);
    chk("l3_data", got_d, 32'hCAFEF00D);
    rd[2] = 0; wr[2] = 0;
    @(negedge clk);
    do_acc(2, 1, 0, 32'd4, 4'h0, 32'h0, got_d, got_e, got_l);
    chk("l3_nowr", got_d, 32'h0BADF00D);

    // Asynchronous reset mid-WAIT of a write discards the write.
    wr[2] = 1; addr[2] = 32'd0; mask[2] = 4'hF; wdata[2] = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    chk("ar_busy_pre", 32'(busy[2]), 32'd1);
    wr[2] = 0;
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy[2]), 32'd0);
    chk("ar_valid", 32'(valid[2]), 32'd0);
    chk("ar_data", rdata[2], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_acc(2, 1, 0, 32'd0, 4'h0, 32'h0, got_d, got_e, got_l);
    chk("ar_lat", 32'(got_l), 32'd4);
    chk("ar_err", 32'(got_e), 32'd0);
    chk("ar_mem0", got_d, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
